// File: rtl/rv32i_types.sv
// Shared RV32I-side widths: rename tags handed out by the reorder buffer and register ids.
package rv32i_types;
    localparam int TAG_W = 4;
    localparam int REG_W = 5;
    localparam int XLEN  = 32;
endpackage

// File: rtl/structs.sv
// Reorder-buffer entry layout and default depth.
package structs;
    localparam int ROB_DEPTH = 8;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] value;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular FIFO of entries filled out of order by the CDB.
// Tag n names entry n-1; tag 0 means the operand already lives in the register file.
module reorder_buffer
    import rv32i_types::*;
    import structs::rob_entry_t;
#(
    parameter int ROB_DEPTH = structs::ROB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             rob_write,
    input  logic [REG_W-1:0] rob_dest,
    output logic [TAG_W-1:0] rob_free_tag,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic [TAG_W-1:0] query_tag1,
    input  logic [TAG_W-1:0] query_tag2,
    output logic             query_ready1,
    output logic             query_ready2,
    output logic [XLEN-1:0]  query_val1,
    output logic [XLEN-1:0]  query_val2,
    output logic             load_reg,
    output logic [REG_W-1:0] reg_id_rob,
    output logic [XLEN-1:0]  reg_val,
    output logic [TAG_W-1:0] tag_rob
);
    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rob_entry_t       entries_q [ROB_DEPTH];
    rob_entry_t       entries_d [ROB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alloc_s, commit_s, cdb_hit_s;
    logic [TAG_W-1:0] qtag_s [2];
    logic             qrdy_s [2];
    logic [XLEN-1:0]  qval_s [2];

    function automatic logic tag_live(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (int'(tag) <= ROB_DEPTH);
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        return PTR_W'(tag - TAG_W'(1));
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rob_full     = (count_q == CNT_W'(ROB_DEPTH));
    assign rob_free_tag = TAG_W'(tail_q) + TAG_W'(1);
    assign alloc_s      = rob_write && !rob_full;
    assign commit_s     = !flush && entries_q[head_q].valid && entries_q[head_q].ready;
    assign cdb_hit_s    = cdb_valid && tag_live(cdb_tag) && entries_q[tag_idx(cdb_tag)].valid;

    // Everything but load_reg is zeroed off-commit so stale storage never leaks.
    assign load_reg   = commit_s && (entries_q[head_q].rd != '0);
    assign reg_id_rob = commit_s ? entries_q[head_q].rd : '0;
    assign reg_val    = commit_s ? entries_q[head_q].value : '0;
    assign tag_rob    = commit_s ? TAG_W'(head_q) + TAG_W'(1) : '0;

    assign qtag_s[0]    = query_tag1;
    assign qtag_s[1]    = query_tag2;
    assign query_ready1 = qrdy_s[0];
    assign query_ready2 = qrdy_s[1];
    assign query_val1   = qval_s[0];
    assign query_val2   = qval_s[1];

    // Operand lookup with same-cycle CDB bypass for the two decoder ports.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            qrdy_s[i] = 1'b0;
            qval_s[i] = '0;
            if (tag_live(qtag_s[i]) && entries_q[tag_idx(qtag_s[i])].valid) begin
                if (cdb_valid && (cdb_tag == qtag_s[i])) begin
                    qrdy_s[i] = 1'b1;
                    qval_s[i] = cdb_value;
                end else if (entries_q[tag_idx(qtag_s[i])].ready) begin
                    qrdy_s[i] = 1'b1;
                    qval_s[i] = entries_q[tag_idx(qtag_s[i])].value;
                end else begin
                    qrdy_s[i] = 1'b0;
                    qval_s[i] = '0;
                end
            end else begin
                qrdy_s[i] = 1'b0;
                qval_s[i] = '0;
            end
        end
    end

    // Next-state: flush wins, otherwise CDB fill, head retire and tail allocate.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_hit_s) begin
                entries_d[tag_idx(cdb_tag)].ready = 1'b1;
                entries_d[tag_idx(cdb_tag)].value = cdb_value;
            end else begin
                entries_d[head_q].valid = entries_q[head_q].valid;
            end
            if (commit_s) begin
                entries_d[head_q].valid = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d                  = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            if (alloc_s) begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].ready = 1'b0;
                entries_d[tail_q].rd    = rob_dest;
                tail_d                  = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CNT_W'(alloc_s) - CNT_W'(commit_s);
        end
    end

    // State registers; entry payload is deliberately left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].ready <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end
endmodule
